// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Purpose  : Op encodings and level-partitioning helpers for shift_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int SH_OP_W = 3;

    localparam logic [SH_OP_W-1:0] SH_SLL = 3'b000;
    localparam logic [SH_OP_W-1:0] SH_SRL = 3'b001;
    localparam logic [SH_OP_W-1:0] SH_SRA = 3'b010;
    localparam logic [SH_OP_W-1:0] SH_ROL = 3'b011;
    localparam logic [SH_OP_W-1:0] SH_ROR = 3'b100;

    function automatic logic is_legal_op(input logic [SH_OP_W-1:0] op);
        return (op <= SH_ROR);
    endfunction

    // First level handled by stage idx: ceil-sized groups, clipped so that
    // every remaining stage still receives at least one level.
    function automatic int stage_first(input int shw, input int stages, input int idx);
        int per;
        int a;
        int b;
        per = (shw + stages - 1) / stages;
        a   = idx * per;
        b   = shw - (stages - idx);
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module   : shift_stage
// Purpose  : Combinational group of N_LVL consecutive barrel-shifter levels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIRST_LVL = 0,
    parameter int N_LVL     = 1
) (
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SH_OP_W-1:0] in_op,
    input  logic [N_LVL-1:0]   in_amt,
    output logic [WIDTH-1:0]   out_data
);

    logic [WIDTH-1:0] w_lvl [N_LVL+1];

    assign w_lvl[0] = in_data;

    generate
        for (genvar k = 0; k < N_LVL; k++) begin : g_lvl
            localparam int c_sh = 1 << (FIRST_LVL + k);
            logic [WIDTH-1:0] w_shifted;

            // Illegal ops fall through unshifted; the error flag travels separately.
            always_comb begin
                w_shifted = w_lvl[k];
                case (in_op)
                    SH_SLL:  w_shifted = w_lvl[k] << c_sh;
                    SH_SRL:  w_shifted = w_lvl[k] >> c_sh;
                    SH_SRA:  w_shifted = $signed(w_lvl[k]) >>> c_sh;
                    SH_ROL:  w_shifted = (w_lvl[k] << c_sh) | (w_lvl[k] >> (WIDTH - c_sh));
                    SH_ROR:  w_shifted = (w_lvl[k] >> c_sh) | (w_lvl[k] << (WIDTH - c_sh));
                    default: w_shifted = w_lvl[k];
                endcase
            end

            assign w_lvl[k+1] = in_amt[k] ? w_shifted : w_lvl[k];
        end
    endgenerate

    assign out_data = w_lvl[N_LVL];

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// Module   : shift_pipe
// Purpose  : Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready,
//            pass-through tag and synchronous flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SH_OP_W-1:0]       in_op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err
);

    localparam int c_shw = $clog2(WIDTH);

    // Index i is the input side of stage i; index STAGES is the output register.
    logic               w_valid [STAGES+1];
    logic [WIDTH-1:0]   w_data  [STAGES+1];
    logic [TAG_W-1:0]   w_tag   [STAGES+1];
    logic               w_err   [STAGES+1];
    logic [SH_OP_W-1:0] w_op    [STAGES];
    logic [c_shw-1:0]   w_amt   [STAGES];
    logic               w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && !flush;

    assign w_valid[0] = in_valid && in_ready;
    assign w_data[0]  = in_data;
    assign w_tag[0]   = in_tag;
    assign w_err[0]   = !is_legal_op(in_op);
    assign w_op[0]    = in_op;
    assign w_amt[0]   = in_amt;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            localparam int c_first = stage_first(c_shw, STAGES, i);
            localparam int c_nlvl  = stage_first(c_shw, STAGES, i + 1) - c_first;

            logic [WIDTH-1:0] w_shifted;
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic [TAG_W-1:0] r_tag;
            logic             r_err;

            shift_stage #(
                .WIDTH     (WIDTH),
                .FIRST_LVL (c_first),
                .N_LVL     (c_nlvl)
            ) u_stage (
                .in_data  (w_data[i]),
                .in_op    (w_op[i]),
                .in_amt   (w_amt[i][c_first +: c_nlvl]),
                .out_data (w_shifted)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_tag   <= '0;
                    r_err   <= 1'b0;
                end else begin
                    if (flush) begin
                        r_valid <= 1'b0;
                    end else if (w_adv) begin
                        r_valid <= w_valid[i];
                    end
                    if (w_adv) begin
                        r_data <= w_shifted;
                        r_tag  <= w_tag[i];
                        r_err  <= w_err[i];
                    end
                end
            end

            assign w_valid[i+1] = r_valid;
            assign w_data[i+1]  = r_data;
            assign w_tag[i+1]   = r_tag;
            assign w_err[i+1]   = r_err;

            // The output stage no longer needs op or amount.
            if (i < STAGES - 1) begin : g_carry
                logic [SH_OP_W-1:0] r_op;
                logic [c_shw-1:0]   r_amt;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_op  <= '0;
                        r_amt <= '0;
                    end else if (w_adv) begin
                        r_op  <= w_op[i];
                        r_amt <= w_amt[i];
                    end
                end

                assign w_op[i+1]  = r_op;
                assign w_amt[i+1] = r_amt;
            end
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES];
    assign out_tag   = w_tag[STAGES];
    assign out_err   = w_err[STAGES];

endmodule

`default_nettype wire
